// File: rtl/sum_pipe_arbiter.sv
// Round-robin arbiter sharing one externally pipelined adder between two
// requesters, with tag-based result routing and a hold/drain handshake.
module sum_pipe_arbiter #(
  parameter int WIDTH   = 4,
  parameter int LATENCY = 2,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset_L,
  input  logic               req0_valid,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               req1_ready,
  output logic               rsp0_valid,
  output logic [WIDTH-1:0]   rsp0_sum,
  output logic               rsp1_valid,
  output logic [WIDTH-1:0]   rsp1_sum,
  output logic [WIDTH-1:0]   pipe_dataA,
  output logic [WIDTH-1:0]   pipe_dataB,
  input  logic [WIDTH-1:0]   pipe_sum,
  input  logic               hold_req,
  output logic               hold_ack,
  output logic [COUNT_W-1:0] issue_count
);

  typedef enum logic [1:0] {RUN, DRAIN, HOLD} state_t;

  state_t             state_q, state_d;
  logic               rr_last_q, rr_last_d;
  logic [WIDTH-1:0]   data_a_q, data_a_d;
  logic [WIDTH-1:0]   data_b_q, data_b_d;
  logic [LATENCY:0]   tag_vld_q, tag_vld_d;
  logic [LATENCY:0]   tag_id_q, tag_id_d;
  logic               rsp0_valid_q, rsp0_valid_d;
  logic               rsp1_valid_q, rsp1_valid_d;
  logic [WIDTH-1:0]   rsp0_sum_q, rsp0_sum_d;
  logic [WIDTH-1:0]   rsp1_sum_q, rsp1_sum_d;
  logic [COUNT_W-1:0] issue_count_q, issue_count_d;
  logic               can_grant, grant0, grant1, grant_any;

  // Arbitration and issue: grants are gated the same cycle hold_req rises.
  always_comb begin
    can_grant = (state_q == RUN) && !hold_req;
    grant0    = can_grant && req0_valid && (!req1_valid || rr_last_q);
    grant1    = can_grant && req1_valid && (!req0_valid || !rr_last_q);
    grant_any = grant0 || grant1;

    rr_last_d = rr_last_q;
    data_a_d  = '0;
    data_b_d  = '0;
    if (grant0) begin
      rr_last_d = 1'b0;
      data_a_d  = req0_a;
      data_b_d  = req0_b;
    end else if (grant1) begin
      rr_last_d = 1'b1;
      data_a_d  = req1_a;
      data_b_d  = req1_b;
    end

    tag_vld_d     = {tag_vld_q[LATENCY-1:0], grant_any};
    tag_id_d      = {tag_id_q[LATENCY-1:0], grant1};
    issue_count_d = issue_count_q + {{(COUNT_W-1){1'b0}}, grant_any};

    // Tag stage LATENCY lines up with the adder output on pipe_sum.
    rsp0_valid_d = tag_vld_q[LATENCY] && !tag_id_q[LATENCY];
    rsp1_valid_d = tag_vld_q[LATENCY] &&  tag_id_q[LATENCY];
    rsp0_sum_d   = rsp0_valid_d ? pipe_sum : rsp0_sum_q;
    rsp1_sum_d   = rsp1_valid_d ? pipe_sum : rsp1_sum_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (hold_req) state_d = DRAIN;
      DRAIN:   if (!hold_req) state_d = RUN;
               else if (tag_vld_q == '0) state_d = HOLD;
      HOLD:    if (!hold_req) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q       <= RUN;
      rr_last_q     <= 1'b1;
      data_a_q      <= '0;
      data_b_q      <= '0;
      tag_vld_q     <= '0;
      tag_id_q      <= '0;
      rsp0_valid_q  <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      rsp0_sum_q    <= '0;
      rsp1_sum_q    <= '0;
      issue_count_q <= '0;
    end else begin
      state_q       <= state_d;
      rr_last_q     <= rr_last_d;
      data_a_q      <= data_a_d;
      data_b_q      <= data_b_d;
      tag_vld_q     <= tag_vld_d;
      tag_id_q      <= tag_id_d;
      rsp0_valid_q  <= rsp0_valid_d;
      rsp1_valid_q  <= rsp1_valid_d;
      rsp0_sum_q    <= rsp0_sum_d;
      rsp1_sum_q    <= rsp1_sum_d;
      issue_count_q <= issue_count_d;
    end
  end

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign pipe_dataA  = data_a_q;
  assign pipe_dataB  = data_b_q;
  assign rsp0_valid  = rsp0_valid_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp0_sum    = rsp0_sum_q;
  assign rsp1_sum    = rsp1_sum_q;
  assign hold_ack    = (state_q == HOLD);
  assign issue_count = issue_count_q;

endmodule

// File: doc/sum_pipe_arbiter.md
Name: sum_pipe_arbiter

Overview:
- Shares one 4-bit two-stage pipelined adder (sum_pipe, 2-cycle latency) between two requesters.
- Accepts operand pairs via valid/ready, grants round-robin, and drives the adder inputs from registers.
- Tags each issued operation and routes the adder result back to the owning requester.
- A hold/drain handshake empties the pipeline before upstream reconfiguration or test access.

Parameters:
WIDTH, 4, operand/result width (must match adder)
LATENCY, 2, adder input-to-sum30_dd latency in clocks
COUNT_W, 8, width of issue counter

Ports:
clk  in  1  system clock, rising edge
reset_L  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has an operand pair
req0_a  in  WIDTH  requester 0 operand A
req0_b  in  WIDTH  requester 0 operand B
req0_ready  out  1  requester 0 accepted this cycle (combinational)
req1_valid  in  1  requester 1 has an operand pair
req1_a  in  WIDTH  requester 1 operand A
req1_b  in  WIDTH  requester 1 operand B
req1_ready  out  1  requester 1 accepted this cycle (combinational)
rsp0_valid  out  1  result for requester 0 valid (one-cycle pulse)
rsp0_sum  out  WIDTH  result for requester 0
rsp1_valid  out  1  result for requester 1 valid (one-cycle pulse)
rsp1_sum  out  WIDTH  result for requester 1
pipe_dataA  out  WIDTH  to adder dataA (registered)
pipe_dataB  out  WIDTH  to adder dataB (registered)
pipe_sum  in  WIDTH  from adder sum30_dd
hold_req  in  1  request pipeline drain and stop granting
hold_ack  out  1  pipeline empty, no grants
issue_count  out  COUNT_W  total operations issued, wraps

Behaviour:
- Reset (async, reset_L=0): pipe_dataA/B=0, all tag valids=0, rsp*_valid=0, rsp*_sum=0, issue_count=0, hold_ack=0, state=RUN, rr_last=1 (req0 wins first contention). Reset mid-operation discards in-flight ops; no responses are produced for them.
- Handshake: transfer when reqN_valid && reqN_ready at a rising edge. readyN is asserted only in RUN with hold_req=0, and at most one ready per cycle.
- Arbitration: if only one valid, grant it. If both valid, grant the requester != rr_last. rr_last updates only on a grant.
- Issue: on grant at edge e, register pipe_dataA/B <= granted operands and tag stage0 <= {valid=1, id}. With no grant, pipe_dataA/B <= 0 and stage0.valid <= 0. Throughput is one op per cycle.
- Tag pipeline: LATENCY+1 stages shift every clock, with no stall. The stage aligned with pipe_sum (stage LATENCY) is used to route the result.
- Response: at edge e+LATENCY+1 (3 cycles after handshake), rspN_valid <= 1 and rspN_sum <= pipe_sum for the tagged id. The other rsp_valid is 0. rsp*_sum holds its last value when not valid. Responses have no backpressure.
- Arithmetic: the sum is mod 2^WIDTH and the carry out is discarded (9+9 -> 2).
- issue_count increments on every grant and wraps from 2^COUNT_W-1 to 0.
- FSM:
  - RUN: grants allowed. hold_req=1 -> DRAIN. Grants are blocked combinationally in the same cycle hold_req rises.
  - DRAIN: no grants. If hold_req=0 -> RUN. Else if all tag stages are invalid -> HOLD.
  - HOLD: hold_ack=1, no grants. hold_req=0 -> RUN, and hold_ack drops on the next cycle.
- If hold_req is asserted in RUN with the pipeline already empty, the FSM passes through DRAIN for one cycle, so hold_ack rises 2 cycles after hold_req.
- The adder is clocked freely and its idx output is not used. Adder output is ignored whenever the aligned tag is invalid.

Test Plan:
- Reset, then req0 a=3 b=5 for one cycle -> req0_ready=1 same cycle; rsp0_valid=1, rsp0_sum=8 exactly 3 cycles later; rsp1_valid stays 0; issue_count=1.
- req0 and req1 both valid continuously (req0 a=1 b=1, req1 a=2 b=2) -> grants alternate 0,1,0,1 starting with 0; rsp sequence 2,4,2,4 with one response per cycle after a 3-cycle fill.
- Overflow: req1 a=9 b=9 -> rsp1_sum=2; a=15 b=1 -> 0.
- Back-to-back: req0 issues 4 ops in consecutive cycles, then hold_req=1 -> all 4 responses delivered; hold_ack rises only after the last tag clears; no ready while hold_req=1; deassert -> grants resume next cycle.
- Reset mid-flight: issue 2 ops, assert reset_L=0 one cycle later -> no rsp_valid ever for those ops; issue_count=0; after release, first contention is granted to req0.
- issue_count wrap: with COUNT_W=2, 5 grants -> issue_count=1.
